// File: rtl/fp_dac_serializer.sv
// Purpose: one-frame buffered float serial DAC driver; optional mantissa rounding under DAC_ROUND_EN.
// Latency: a frame accepted before tick 0 is serialised in that frame, starting at tick EXP_MAX+2.
// Backpressure: oReady drops while the single-frame buffer is full; an empty buffer at tick 0 replays the last frame.
module fp_dac_serializer #(
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_W    = 16,
    parameter int MANT_W      = 10,
    parameter int EXP_W       = 3,
    parameter int EXP_MAX     = 6,
    parameter int SLOT_BITS   = 18,
    parameter int FRAME_TICKS = 160
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic                         iClkEn,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic [CHANNELS*SAMPLE_W-1:0] iSamples,
    output logic                         oDacClk,
    output logic                         oDacSd,
    output logic [CHANNELS-1:0]          oDacLoad,
    output logic                         oUnderrun
);

    localparam int SER_START = EXP_MAX + 2;
    localparam int TW        = $clog2(FRAME_TICKS);
    localparam int MSB       = SAMPLE_W - 1;
    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

    if (EXP_MAX > 2**EXP_W - 2) begin : gChkExp
        $error("EXP_MAX does not fit the exponent field");
    end
    if (SLOT_BITS < MANT_W + EXP_W) begin : gChkSlot
        $error("SLOT_BITS too small for exponent plus mantissa");
    end
    if (FRAME_TICKS < EXP_MAX + 2 + 4*(CHANNELS*SLOT_BITS + 1)) begin : gChkFrame
        $error("FRAME_TICKS too small for the serial frame");
    end
    if (SAMPLE_W <= MANT_W || MANT_W < 2) begin : gChkMant
        $error("SAMPLE_W must exceed MANT_W and MANT_W must be at least 2");
    end

    logic                         full;
    logic                         everAcc;
    logic [CHANNELS*SAMPLE_W-1:0] bufD;
    logic [CHANNELS*SAMPLE_W-1:0] lastD;
    logic [CHANNELS*SAMPLE_W-1:0] src;
    logic [TW-1:0]                tick;
    logic [SAMPLE_W-1:0]          s [CHANNELS];
    logic [EXP_W-1:0]             n [CHANNELS];
    logic [SLOT_BITS-1:0]         word [CHANNELS];
    logic [MANT_W-1:0]            mant;
    logic [TW-1:0]                rel;
    logic                         nextSd;
    logic                         nextClk;
    logic [CHANNELS-1:0]          nextLoad;

    assign oReady = ~full;
    assign src    = full ? bufD : lastD;

    always_comb begin
        mant = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mant = {~s[c][MSB], s[c][MSB-1 -: MANT_W-1]};
`ifdef DAC_ROUND_EN
            // Round to nearest, but never wrap the positive full-scale code.
            if (s[c][MSB-MANT_W] && mant != '1) mant = mant + 1'b1;
`endif
            word[c] = '0;
            word[c][SLOT_BITS-1 -: MANT_W+EXP_W] = {EXP_ALL1 - n[c], mant};
        end
    end

    // Each serial bit spans 4 ticks; the load strobe of channel c sits in the slot after its last bit.
    always_comb begin
        nextSd   = 1'b0;
        nextClk  = 1'b0;
        nextLoad = '0;
        rel      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (tick >= TW'(SER_START + 4*c*SLOT_BITS) &&
                tick <  TW'(SER_START + 4*(c+1)*SLOT_BITS)) begin
                rel     = tick - TW'(SER_START + 4*c*SLOT_BITS);
                nextClk = (rel[1:0] == 2'd2);
                for (int k = 0; k < SLOT_BITS; k++) begin
                    if (rel[TW-1:2] == (TW-2)'(k)) nextSd = word[c][k];
                end
            end
            if (tick >= TW'(SER_START + 4*(c+1)*SLOT_BITS) &&
                tick <  TW'(SER_START + 4*(c+1)*SLOT_BITS + 4)) begin
                nextLoad[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            full      <= 1'b0;
            everAcc   <= 1'b0;
            bufD      <= '0;
            lastD     <= '0;
            tick      <= '0;
            oDacClk   <= 1'b0;
            oDacSd    <= 1'b0;
            oDacLoad  <= '0;
            oUnderrun <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                s[c] <= '0;
                n[c] <= '0;
            end
        end else begin
            oUnderrun <= 1'b0;
            if (iClkEn) begin
                tick <= (tick == TW'(FRAME_TICKS-1)) ? '0 : tick + 1'b1;
                if (tick == '0) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        s[c] <= src[c*SAMPLE_W +: SAMPLE_W];
                        n[c] <= '0;
                    end
                    if (full) lastD <= bufD;
                    else      oUnderrun <= everAcc;
                end else if (tick <= TW'(EXP_MAX)) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (s[c][MSB] == s[c][MSB-1] && n[c] < EXP_W'(EXP_MAX)) begin
                            s[c] <= s[c] << 1;
                            n[c] <= n[c] + 1'b1;
                        end
                    end
                end
                oDacSd   <= nextSd;
                oDacClk  <= nextClk;
                oDacLoad <= nextLoad;
            end
            // Capture frees the buffer; otherwise an empty buffer accepts, even alongside an empty capture.
            if (iClkEn && tick == '0 && full) begin
                full <= 1'b0;
            end else if (iValid && !full) begin
                full    <= 1'b1;
                bufD    <= iSamples;
                everAcc <= 1'b1;
            end
        end
    end

endmodule
